id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 146 ++++++++++++++
 tb/tb_id_ex_reg.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush bubbles, stall hold and a saturating bubble counter.
// Optional FWD_SRC_EN macro adds src1/src2 register numbers for forwarding.
module id_ex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        freeze,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic        imm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        wb_en_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic [3:0]  status_in,
`ifdef FWD_SRC_EN
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  output logic [3:0]  src1_out,
  output logic [3:0]  src2_out,
`endif
  output logic [31:0] pc_out,
  output logic [31:0] val_rn_out,
  output logic [31:0] val_rm_out,
  output logic        imm_out,
  output logic [11:0] shift_operand_out,
  output logic [23:0] signed_imm_24_out,
  output logic [3:0]  dest_out,
  output logic [3:0]  exe_cmd_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic        wb_en_out,
  output logic        b_out,
  output logic        s_out,
  output logic [3:0]  status_out,
  output logic        mem_rw_out,
  output logic        valid_out,
  output logic [15:0] bubble_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  exe_cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic        b;
    logic        s;
    logic [3:0]  status;
    logic        valid;
`ifdef FWD_SRC_EN
    logic [3:0]  src1;
    logic [3:0]  src2;
`endif
  } id_ex_t;

  id_ex_t      q;
  id_ex_t      d_load;
  logic [15:0] bubble_q;
  logic        do_rst;
  logic        do_flush;
  logic        do_hold;

  always_comb begin
    d_load               = '0;
    d_load.pc            = pc_in;
    d_load.val_rn        = val_rn_in;
    d_load.val_rm        = val_rm_in;
    d_load.imm           = imm_in;
    d_load.shift_operand = shift_operand_in;
    d_load.signed_imm_24 = signed_imm_24_in;
    d_load.dest          = dest_in;
    d_load.exe_cmd       = exe_cmd_in;
    d_load.status        = status_in;
    // invalid slots keep data but must never act
    d_load.mem_r_en      = mem_r_en_in & valid_in;
    d_load.mem_w_en      = mem_w_en_in & valid_in;
    d_load.wb_en         = wb_en_in & valid_in;
    d_load.b             = b_in & valid_in;
    d_load.s             = s_in & valid_in;
    d_load.valid         = valid_in;
`ifdef FWD_SRC_EN
    d_load.src1          = src1_in;
    d_load.src2          = src2_in;
`endif
  end

  assign do_rst   = rst;
  assign do_flush = ~rst & flush;
  assign do_hold  = ~rst & ~flush & freeze;

  always_ff @(posedge clk) begin
    unique case (1'b1)
      do_rst: begin
        q        <= '0;
        bubble_q <= '0;
      end
      do_flush: begin
        q <= '0;
        if (bubble_q != 16'hFFFF)
          bubble_q <= bubble_q + 16'd1;
      end
      do_hold: begin
        q        <= q;
        bubble_q <= bubble_q;
      end
      default: q <= d_load;
    endcase
  end

  assign pc_out            = q.pc;
  assign val_rn_out        = q.val_rn;
  assign val_rm_out        = q.val_rm;
  assign imm_out           = q.imm;
  assign shift_operand_out = q.shift_operand;
  assign signed_imm_24_out = q.signed_imm_24;
  assign dest_out          = q.dest;
  assign exe_cmd_out       = q.exe_cmd;
  assign mem_r_en_out      = q.mem_r_en;
  assign mem_w_en_out      = q.mem_w_en;
  assign wb_en_out         = q.wb_en;
  assign b_out             = q.b;
  assign s_out             = q.s;
  assign status_out        = q.status;
  assign valid_out         = q.valid;
  assign mem_rw_out        = q.mem_r_en | q.mem_w_en;
  assign bubble_count      = bubble_q;
`ifdef FWD_SRC_EN
  assign src1_out          = q.src1;
  assign src2_out          = q.src2;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed plus randomized bench for id_ex_reg against a behavioural model.
// Honours FWD_SRC_EN when defined.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst, flush, freeze, valid_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in, exe_cmd_in, status_in;
  logic        mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        imm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic [3:0]  dest_out, exe_cmd_out, status_out;
  logic        mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out;
  logic        mem_rw_out, valid_out;
  logic [15:0] bubble_count;
`ifdef FWD_SRC_EN
  logic [3:0]  src1_in, src2_in, src1_out, src2_out;
`endif

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pc, m_rn, m_rm;
  logic        m_imm;
  logic [11:0] m_sh;
  logic [23:0] m_si;
  logic [3:0]  m_dest, m_cmd, m_st;
  logic        m_r, m_w, m_wb, m_b, m_s, m_rw, m_v;
  logic [15:0] m_cnt;
  logic [3:0]  m_s1, m_s2;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .valid_in(valid_in), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .imm_in(imm_in), .shift_operand_in(shift_operand_in),
    .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in),
    .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .b_in(b_in), .s_in(s_in), .status_in(status_in),
`ifdef FWD_SRC_EN
    .src1_in(src1_in), .src2_in(src2_in),
    .src1_out(src1_out), .src2_out(src2_out),
`endif
    .pc_out(pc_out), .val_rn_out(val_rn_out),
    .val_rm_out(val_rm_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out),
    .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out), .exe_cmd_out(exe_cmd_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .wb_en_out(wb_en_out), .b_out(b_out), .s_out(s_out),
    .status_out(status_out), .mem_rw_out(mem_rw_out),
    .valid_out(valid_out), .bubble_count(bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] v);
    valid_in = v[0];
    pc_in = v; val_rn_in = v; val_rm_in = v;
    imm_in = v[0]; shift_operand_in = v[11:0];
    signed_imm_24_in = v[23:0];
    dest_in = v[3:0]; exe_cmd_in = v[3:0]; status_in = v[3:0];
    mem_r_en_in = v[0]; mem_w_en_in = v[0];
    wb_en_in = v[0]; b_in = v[0]; s_in = v[0];
`ifdef FWD_SRC_EN
    src1_in = v[3:0]; src2_in = v[3:0];
`endif
  endtask

  task automatic rand_in();
    valid_in = 1'($urandom);
    pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
    imm_in = 1'($urandom); shift_operand_in = 12'($urandom);
    signed_imm_24_in = 24'($urandom);
    dest_in = 4'($urandom); exe_cmd_in = 4'($urandom);
    status_in = 4'($urandom);
    mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom);
    wb_en_in = 1'($urandom); b_in = 1'($urandom); s_in = 1'($urandom);
`ifdef FWD_SRC_EN
    src1_in = 4'($urandom); src2_in = 4'($urandom);
`endif
  endtask

  // What the stage should hold after the coming edge, from the rules directly.
  task automatic model_step();
    if (rst || flush) begin
      {m_pc, m_rn, m_rm, m_imm, m_sh, m_si} = '0;
      {m_dest, m_cmd, m_st, m_s1, m_s2} = '0;
      {m_r, m_w, m_wb, m_b, m_s, m_rw, m_v} = '0;
      if (rst) m_cnt = 16'h0;
      else if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'h1;
    end else if (!freeze) begin
      m_pc = pc_in; m_rn = val_rn_in; m_rm = val_rm_in;
      m_imm = imm_in; m_sh = shift_operand_in; m_si = signed_imm_24_in;
      m_dest = dest_in; m_cmd = exe_cmd_in; m_st = status_in;
      m_v = valid_in;
      m_r = valid_in ? mem_r_en_in : 1'b0;
      m_w = valid_in ? mem_w_en_in : 1'b0;
      m_wb = valid_in ? wb_en_in : 1'b0;
      m_b = valid_in ? b_in : 1'b0;
      m_s = valid_in ? s_in : 1'b0;
      m_rw = valid_in && (mem_r_en_in || mem_w_en_in);
`ifdef FWD_SRC_EN
      m_s1 = src1_in; m_s2 = src2_in;
`endif
    end
  endtask

  task automatic check_model();
    chk("pc", pc_out, m_pc);
    chk("val_rn", val_rn_out, m_rn);
    chk("val_rm", val_rm_out, m_rm);
    chk("imm", 32'(imm_out), 32'(m_imm));
    chk("shift_op", 32'(shift_operand_out), 32'(m_sh));
    chk("simm24", 32'(signed_imm_24_out), 32'(m_si));
    chk("dest", 32'(dest_out), 32'(m_dest));
    chk("exe_cmd", 32'(exe_cmd_out), 32'(m_cmd));
    chk("status", 32'(status_out), 32'(m_st));
    chk("mem_r", 32'(mem_r_en_out), 32'(m_r));
    chk("mem_w", 32'(mem_w_en_out), 32'(m_w));
    chk("wb_en", 32'(wb_en_out), 32'(m_wb));
    chk("b", 32'(b_out), 32'(m_b));
    chk("s", 32'(s_out), 32'(m_s));
    chk("mem_rw", 32'(mem_rw_out), 32'(m_rw));
    chk("valid", 32'(valid_out), 32'(m_v));
    chk("bubbles", 32'(bubble_count), 32'(m_cnt));
`ifdef FWD_SRC_EN
    chk("src1", 32'(src1_out), 32'(m_s1));
    chk("src2", 32'(src2_out), 32'(m_s2));
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    m_cnt = 16'h0;
    // reset with every input high
    rst = 1'b1; flush = 1'b1; freeze = 1'b1;
    set_in('1);
    tick();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_bubbles", 32'(bubble_count), 32'h0);

    // plain store load
    rst = 1'b0; flush = 1'b0; freeze = 1'b0;
    set_in(32'h0);
    pc_in = 32'h10; val_rm_in = 32'hDEADBEEF;
    mem_w_en_in = 1'b1; valid_in = 1'b1;
    tick();
    chk("ld_pc", pc_out, 32'h10);
    chk("ld_rm", val_rm_out, 32'hDEADBEEF);
    chk("ld_rw", 32'(mem_rw_out), 32'h1);
    chk("ld_valid", 32'(valid_out), 32'h1);

    // freeze holds for three cycles
    freeze = 1'b1;
    set_in(32'h55555555);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_pc", pc_out, 32'h10);
      chk("frz_rm", val_rm_out, 32'hDEADBEEF);
    end
    freeze = 1'b0;

    // flush wins over freeze
    set_in(32'h0);
    wb_en_in = 1'b1; valid_in = 1'b1;
    tick();
    flush = 1'b1; freeze = 1'b1;
    tick();
    chk("ff_wb", 32'(wb_en_out), 32'h0);
    chk("ff_valid", 32'(valid_out), 32'h0);
    chk("ff_bubbles", 32'(bubble_count), 32'h1);
    flush = 1'b0; freeze = 1'b0;

    // invalid slot keeps data, drops control
    set_in(32'h0);
    valid_in = 1'b0; s_in = 1'b1; dest_in = 4'hA;
`ifdef FWD_SRC_EN
    src1_in = 4'h3;
`endif
    tick();
    chk("inv_s", 32'(s_out), 32'h0);
    chk("inv_valid", 32'(valid_out), 32'h0);
    chk("inv_dest", 32'(dest_out), 32'hA);
`ifdef FWD_SRC_EN
    chk("inv_src1", 32'(src1_out), 32'h3);
`endif

    // reset during a stall drops the held instruction
    rand_in(); valid_in = 1'b1;
    tick();
    freeze = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("rstall_pc", pc_out, 32'h0);
    rst = 1'b0; freeze = 1'b0;
    set_in(32'h12345678); valid_in = 1'b1;
    tick();
    chk("post_rst_pc", pc_out, 32'h12345678);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      flush = ($urandom_range(0, 7) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      rand_in();
      tick();
    end

    // counter saturation
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    tick();
    rst = 1'b0; flush = 1'b1;
    for (int i = 0; i < 16'hFFFE; i++) begin
      model_step();
      @(posedge clk);
    end
    #1;
    chk("pre_sat", 32'(bubble_count), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat", 32'(bubble_count), 32'hFFFF);
    end
    flush = 1'b0; freeze = 1'b1;
    tick();
    chk("sat_hold", 32'(bubble_count), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
